// File: rtl/cosine_match_pkg.sv
// Shared types and width helpers for the cosine match engine.
// MATCH_THRESH_EN adds the CMP state used by the threshold compare.
package cosine_match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
`ifdef MATCH_THRESH_EN
    CMP,
`endif
    DONE
  } state_t;

  localparam logic [1:0] SEL_PROBE = 2'd1;
  localparam logic [1:0] SEL_REF   = 2'd2;

  function automatic int acc_w(input int d_w, input int ele_num);
    return 2 * d_w + $clog2(ele_num);
  endfunction

  function automatic int slot_w(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/cos_mac_lane.sv
// Multiply-accumulate lane: a*b, a*a and b*b summed into
// full-width accumulators, cleared by clr, stepped by en.
module cos_mac_lane #(
  parameter int D_W   = 16,
  parameter int ACC_W = 39
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [D_W-1:0]   a,
  input  logic signed [D_W-1:0]   b,
  output logic signed [ACC_W-1:0] dot,
  output logic [ACC_W-1:0]        nrm_a,
  output logic [ACC_W-1:0]        nrm_b
);

  logic signed [2*D_W-1:0] p_ab;
  logic signed [2*D_W-1:0] p_aa;
  logic signed [2*D_W-1:0] p_bb;

  always_comb begin
    p_ab = a * b;
    p_aa = a * a;
    p_bb = b * b;
  end

  // squares are never negative, so zero-extension is exact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot   <= '0;
      nrm_a <= '0;
      nrm_b <= '0;
    end else if (clr) begin
      dot   <= '0;
      nrm_a <= '0;
      nrm_b <= '0;
    end else if (en) begin
      dot   <= dot + ACC_W'(p_ab);
      nrm_a <= nrm_a + ACC_W'($unsigned(p_aa));
      nrm_b <= nrm_b + ACC_W'($unsigned(p_bb));
    end
  end

endmodule

// File: rtl/cosine_match_engine.sv
// Probe vs stored reference dot product and norms engine.
// MATCH_THRESH_EN adds thr_sq/match and a two-cycle CMP stage.
module cosine_match_engine
  import cosine_match_pkg::*;
#(
  parameter int  D_W     = 16,
  parameter int  ELE_NUM = 128,
  parameter int  SLOTS   = 4,
  localparam int ACC_W   = acc_w(D_W, ELE_NUM),
  localparam int SW      = slot_w(SLOTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [1:0]              vct_sel,
  input  logic [SW-1:0]           slot,
  input  logic [D_W-1:0]          data_in,
  input  logic                    start,
  output logic                    load_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic signed [ACC_W-1:0] dot_out,
  output logic [ACC_W-1:0]        nrm_a_out,
  output logic [ACC_W-1:0]        nrm_b_out
`ifdef MATCH_THRESH_EN
  ,
  input  logic [15:0]             thr_sq,
  output logic                    match
`endif
);

  localparam int IW = $clog2(ELE_NUM);
  localparam logic [IW-1:0] LAST = IW'(ELE_NUM - 1);

  state_t state, state_nx;

  logic [IW-1:0]    load_idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic [1:0]       cur_sel;
  logic [SW-1:0]    cur_slot;
  logic [SW-1:0]    cmp_slot;
  logic             probe_valid;
  logic [SLOTS-1:0] ref_valid;

  logic signed [D_W-1:0] probe_mem [ELE_NUM];
  logic signed [D_W-1:0] ref_mem [SLOTS][ELE_NUM];
  logic signed [D_W-1:0] a_q;
  logic signed [D_W-1:0] b_q;
  logic                  rd_vld;

  logic idle_ld;
  logic start_ok;
  logic src_ok;
  logic go;
  logic go_err;
  logic wr_tgt;
  logic wr_ok;
  logic switch_t;
  logic wr_last;
  logic auto_go;

  logic signed [ACC_W-1:0] acc_dot;
  logic [ACC_W-1:0]        acc_na;
  logic [ACC_W-1:0]        acc_nb;

  always_comb begin
    idle_ld  = (state == IDLE) || (state == LOAD);
    start_ok = start && idle_ld && (load_idx == '0);
    src_ok   = probe_valid && ref_valid[slot];
    go_err   = start_ok && !src_ok;
    wr_tgt   = (vct_sel == SEL_PROBE) || (vct_sel == SEL_REF);
    wr_ok    = we && idle_ld && wr_tgt && !start_ok;
    // a new target abandons whatever partial load was in flight
    switch_t = (load_idx != '0) &&
               ((vct_sel != cur_sel) ||
                ((vct_sel == SEL_REF) && (slot != cur_slot)));
    wr_idx   = switch_t ? '0 : load_idx;
    wr_last  = wr_ok && (wr_idx == LAST);
    auto_go  = wr_last && (vct_sel == SEL_REF) && probe_valid;
    go       = (start_ok && src_ok) || auto_go;
  end

`ifdef MATCH_THRESH_EN
  logic                      cmp_ph;
  logic                      dot_pos;
  logic                      match_c;
  logic signed [2*ACC_W-1:0] sq_dot;
  logic [2*ACC_W-1:0]        sq_nrm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_ph  <= 1'b0;
      dot_pos <= 1'b0;
      match_c <= 1'b0;
      sq_dot  <= '0;
      sq_nrm  <= '0;
    end else if (state == CMP) begin
      cmp_ph <= !cmp_ph;
      if (!cmp_ph) begin
        sq_dot  <= acc_dot * acc_dot;
        sq_nrm  <= acc_na * acc_nb;
        dot_pos <= acc_dot > 0;
      end else begin
        match_c <= dot_pos &&
                   ({sq_dot, 16'h0000} >= thr_sq * sq_nrm);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        load_ready = 1'b1;
        if (go)         state_nx = RUN;
        else if (wr_ok) state_nx = wr_last ? IDLE : LOAD;
      end
      RUN: begin
        busy = 1'b1;
        if (rd_idx == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
`ifdef MATCH_THRESH_EN
        if (!rd_vld) state_nx = CMP;
`else
        if (!rd_vld) state_nx = DONE;
`endif
      end
`ifdef MATCH_THRESH_EN
      CMP: begin
        busy = 1'b1;
        if (cmp_ph) state_nx = DONE;
      end
`endif
      DONE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx    <= '0;
      rd_idx      <= '0;
      cur_sel     <= '0;
      cur_slot    <= '0;
      cmp_slot    <= '0;
      probe_valid <= 1'b0;
      ref_valid   <= '0;
      rd_vld      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dot_out     <= '0;
      nrm_a_out   <= '0;
      nrm_b_out   <= '0;
`ifdef MATCH_THRESH_EN
      match       <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      rd_vld <= state == RUN;
      if (state == RUN) rd_idx <= rd_idx + 1'b1;
      if (go) begin
        rd_idx   <= '0;
        cmp_slot <= slot;
      end
      if (wr_ok) begin
        cur_sel  <= vct_sel;
        cur_slot <= slot;
        load_idx <= wr_idx + 1'b1;
        // first write invalidates the target, last write validates it
        if ((wr_idx == '0) || wr_last) begin
          if (vct_sel == SEL_PROBE) probe_valid     <= wr_last;
          else                      ref_valid[slot] <= wr_last;
        end
      end
      if (go_err) begin
        done      <= 1'b1;
        err       <= 1'b1;
        dot_out   <= '0;
        nrm_a_out <= '0;
        nrm_b_out <= '0;
`ifdef MATCH_THRESH_EN
        match     <= 1'b0;
`endif
      end else if (state == DONE) begin
        done      <= 1'b1;
        err       <= 1'b0;
        dot_out   <= acc_dot;
        nrm_a_out <= acc_na;
        nrm_b_out <= acc_nb;
`ifdef MATCH_THRESH_EN
        match     <= match_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && (vct_sel == SEL_PROBE)) probe_mem[wr_idx] <= data_in;
    if (wr_ok && (vct_sel == SEL_REF))   ref_mem[slot][wr_idx] <= data_in;
    a_q <= probe_mem[rd_idx];
    b_q <= ref_mem[cmp_slot][rd_idx];
  end

  cos_mac_lane #(
    .D_W   (D_W),
    .ACC_W (ACC_W)
  ) u_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .en    (rd_vld),
    .a     (a_q),
    .b     (b_q),
    .dot   (acc_dot),
    .nrm_a (acc_na),
    .nrm_b (acc_nb)
  );

endmodule
